// File: rtl/xtea_pkg.sv
// rtl/xtea_pkg.sv - shared types and widths for the XTEA request scheduler
package xtea_pkg;

  localparam int XTEA_BLK_W = 64;
  localparam int XTEA_KEY_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker, searches upward from ptr+1
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    // i = NREQ wraps back to ptr itself, so the last winner is considered last
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(ptr_i) + i) % NREQ);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xtea_sched.sv
// rtl/xtea_sched.sv - round-robin scheduler sharing one iterative XTEA core
// Optional watchdog abort: define XTEA_SCHED_TIMEOUT_EN.
module xtea_sched
  import xtea_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ*XTEA_BLK_W-1:0]   req_data,
  input  logic [NREQ*XTEA_KEY_W-1:0]   req_key,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NREQ)-1:0]      rsp_id,
  output logic [XTEA_BLK_W-1:0]        rsp_data,
  output logic                         rsp_err,
  output logic                         core_start,
  output logic [XTEA_BLK_W-1:0]        core_in,
  output logic [XTEA_KEY_W-1:0]        core_key,
  input  logic                         core_done,
  input  logic [XTEA_BLK_W-1:0]        core_out
);

  localparam int IW = $clog2(NREQ);

  sched_state_t          state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [XTEA_BLK_W-1:0] blk_q, blk_d;
  logic [XTEA_KEY_W-1:0] key_q, key_d;
  logic [XTEA_BLK_W-1:0] rdata_q, rdata_d;
  logic                  err_d;

  logic [NREQ-1:0]       arb_gnt;
  logic [IW-1:0]         arb_idx;
  logic                  arb_any;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

`ifdef XTEA_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    blk_d   = blk_q;
    key_d   = key_q;
    rdata_d = rdata_q;
`ifdef XTEA_SCHED_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`else
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          idx_d   = arb_idx;
          blk_d   = req_data[int'(arb_idx)*XTEA_BLK_W +: XTEA_BLK_W];
          key_d   = req_key[int'(arb_idx)*XTEA_KEY_W +: XTEA_KEY_W];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
`ifdef XTEA_SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        // a done arriving in the same cycle as the watchdog limit still wins
        if (core_done) begin
          rdata_d = core_out;
          err_d   = 1'b0;
          state_d = RESP;
`ifdef XTEA_SCHED_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      RESP: begin
        if (rsp_ready) begin
          ptr_d   = idx_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NREQ - 1);
      idx_q   <= '0;
      blk_q   <= '0;
      key_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      blk_q   <= blk_d;
      key_q   <= key_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef XTEA_SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign rsp_err = err_q;
`else
  // without the watchdog the limit and the abort flag have no role
  logic unused_timeout;
  assign unused_timeout = (^TIMEOUT) ^ err_d;
  assign rsp_err        = 1'b0;
`endif

  assign req_ready  = (state_q == IDLE && !reset) ? arb_gnt : '0;
  assign core_start = (state_q == ISSUE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = idx_q;
  assign rsp_data   = rdata_q;
  assign core_in    = blk_q;
  assign core_key   = key_q;

endmodule

// File: doc/xtea_sched.md
# xtea_sched

Round-robin scheduler sharing one iterative XTEA encryption core among NREQ requesters. Each requester offers a 64-bit block plus 128-bit key over a valid/ready handshake. The scheduler grants one request at a time, launches the core, waits for completion, and returns the ciphertext tagged with the requester index. It sits between the client ports and the single core instance, which has a start/done handshake.

## Interface
- NREQ, 4: number of requesters, 2..16.
- TIMEOUT, 64: watchdog limit in cycles; used only with XTEA_SCHED_TIMEOUT_EN.
- clk  in  1: clock, rising edge.
- reset  in  1: synchronous, active-high.
- req_valid  in  NREQ: request present, one bit per requester.
- req_ready  out  NREQ: accept strobe, at most one bit set.
- req_data  in  NREQ*64: plaintext blocks; requester i uses bits [64i+63:64i].
- req_key  in  NREQ*128: keys; requester i uses bits [128i+127:128i].
- rsp_valid  out  1: result available.
- rsp_ready  in  1: consumer accepts the result.
- rsp_id  out  $clog2(NREQ): index of the requester that owns the result.
- rsp_data  out  64: ciphertext.
- rsp_err  out  1: watchdog abort. Tied 0 without the macro.
- core_start  out  1: one-cycle launch pulse to the core.
- core_in  out  64: block to the core, held from ISSUE until done.
- core_key  out  128: key to the core, held from ISSUE until done.
- core_done  in  1: core completion pulse, result valid in the same cycle.
- core_out  in  64: core result.

## Operation
- States, in xtea_pkg: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - rr_arbiter picks the first asserted req_valid, searching upward from ptr+1 modulo NREQ.
  - req_ready is asserted combinationally, only in IDLE, only for the winning index.
  - When valid and ready are both high: latch data, key and index, then go to ISSUE.
- ISSUE: core_start=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - On core_done: capture core_out into rsp_data, set rsp_err=0, go to RESP.
  - A core_done seen in any other state is ignored.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_err stay stable until rsp_ready.
  - On rsp_valid & rsp_ready: ptr <= served index, go to IDLE.
- Fairness: a requester that keeps valid high is served within NREQ transactions.
- Only one transaction is in flight. No new grant is made until the response handshake completes.
- The pointer advances only on response completion, including completion of a watchdog abort.
- Reset values:
  - state=IDLE.
  - ptr=NREQ-1, so requester 0 wins first.
  - All outputs 0: req_ready, core_start, rsp_valid, rsp_err, rsp_id, rsp_data, core_in, core_key.
- Reset mid-transaction aborts with no response. The core is reset by the same signal.

## Timing
- Accept in cycle T → core_start in T+1 → core_done in T+1+L → rsp_valid in T+2+L.
- Best-case gap from one rsp handshake to the next accept: 1 cycle (IDLE).
- Inputs need not remain stable after acceptance.
- If rsp_ready is already high when rsp_valid rises, the response completes in that same cycle.
- If req_valid drops without a grant, no state change occurs.

## Configuration
- XTEA_SCHED_TIMEOUT_EN defined:
  - A counter is cleared in ISSUE and increments each cycle in WAIT.
  - When it reaches TIMEOUT with no core_done: go to RESP with rsp_err=1 and rsp_data=0.
  - A core_done in the cycle the count hits TIMEOUT wins: normal response, rsp_err=0.
- XTEA_SCHED_TIMEOUT_EN undefined: no counter is built, WAIT is unbounded, rsp_err is constant 0.

## Structure
- Package xtea_pkg holds:
  - the sched_state_t enum;
  - XTEA_BLK_W=64 and XTEA_KEY_W=128.
- Sub-module rr_arbiter holds the combinational round-robin picker.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant, index, any.

## Test plan
- Single request: req 2, data 64'h0, key 128'h0, core model L=34 → accept at T, core_start at T+1, rsp_id=2 and rsp_data=64'hDEE9D4D8F7131ED9 at T+36.
- All four requesters valid from reset, rsp_ready=1 → service order 0,1,2,3,0.
- Backpressure: rsp_ready held low for 10 cycles → rsp_valid/rsp_data/rsp_id stable, no req_ready, no core_start during the stall.
- Spurious core_done pulsed in IDLE, then a normal request → ignored, correct rsp_data.
- Reset asserted during WAIT → next cycle state IDLE, rsp_valid=0, ptr=NREQ-1, next grant goes to requester 0.
- With XTEA_SCHED_TIMEOUT_EN and TIMEOUT=64, core never sends done → rsp_err=1, rsp_data=0 at T+66, pointer advanced.
